// File: rtl/inv_key_sched_ctrl_if.sv
// Bus bundle for the AES-128 inverse key schedule controller: start/load,
// backward key generator hookup and the round-key read port.
// Optional key check ports are present when KSC_CHECK_EN is defined.
interface inv_key_sched_ctrl_if #(
  parameter int KW = 128
) ();
  logic          start;
  logic [KW-1:0] last_key;
  logic [3:0]    gk_round;
  logic [KW-1:0] gk_inp_key;
  logic [KW-1:0] gk_out_key;
  logic          busy;
  logic          keys_valid;
  logic          done;
  logic          rd_en;
  logic [3:0]    rd_idx;
  logic [KW-1:0] rd_key;
  logic          rd_vld;
`ifdef KSC_CHECK_EN
  logic [KW-1:0] exp_key0;
  logic          key_err;
`endif

  // Controller side
  modport slave (
    input  start, last_key, gk_out_key, rd_en, rd_idx,
`ifdef KSC_CHECK_EN
    input  exp_key0,
    output key_err,
`endif
    output gk_round, gk_inp_key, busy, keys_valid, done, rd_key, rd_vld
  );

  // Host / generator side
  modport master (
    output start, last_key, gk_out_key, rd_en, rd_idx,
`ifdef KSC_CHECK_EN
    output exp_key0,
    input  key_err,
`endif
    input  gk_round, gk_inp_key, busy, keys_valid, done, rd_key, rd_vld
  );
endinterface

// File: rtl/inv_key_sched_ctrl.sv
// AES-128 inverse key schedule sequencer. Loads the round-NR key, walks the
// external combinational backward key generator from round NR-1 down to 0,
// and stores every round key in a local key file read by index.
// Optional macro KSC_CHECK_EN: compares the final (round-0) key against a
// reference sampled at start and flags a mismatch on key_err.
module inv_key_sched_ctrl #(
  parameter int NR = 10,
  parameter int KW = 128
) (
  input  logic                 clk,
  input  logic                 rst_n,
  inv_key_sched_ctrl_if.slave  bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] EXPAND = 2'd1;
  localparam logic [1:0] READY  = 2'd2;

  localparam logic [3:0] LAST = 4'(NR);

  logic [1:0]    state;
  logic [3:0]    rcnt;
  logic [KW-1:0] work;
  logic          busy;
  logic          keys_valid;
  logic          done;
  logic [KW-1:0] rd_key;
  logic          rd_vld;

  logic [KW-1:0] key_file [0:NR];

  logic          wr_en;
  logic [3:0]    wr_addr;
  logic [KW-1:0] wr_data;
  logic          start_ok;

  // Start is only honoured while not expanding
  assign start_ok = bus.start && (state == IDLE || state == READY);

  // Single key file write port: last_key on start, generator output while expanding
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = rcnt;
    wr_data = bus.gk_out_key;
    if (start_ok) begin
      wr_en   = 1'b1;
      wr_addr = LAST;
      wr_data = bus.last_key;
    end else if (state == EXPAND) begin
      wr_en   = 1'b1;
    end
  end

  // Key file storage, no reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (wr_en) key_file[wr_addr] <= wr_data;
  end

`ifdef KSC_CHECK_EN
  logic [KW-1:0] exp_key0;
  logic          key_err;

  // Reference capture at start and final-key compare
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_key0 <= '0;
      key_err  <= 1'b0;
    end else if (start_ok) begin
      exp_key0 <= bus.exp_key0;
      key_err  <= 1'b0;
    end else if (state == EXPAND && rcnt == 4'd0) begin
      key_err  <= (bus.gk_out_key != exp_key0);
    end
  end

  assign bus.key_err = key_err;
`endif

  // Sequencer: load, count rounds down, signal completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rcnt       <= 4'd0;
      work       <= '0;
      busy       <= 1'b0;
      keys_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, READY: begin
          if (bus.start) begin
            work       <= bus.last_key;
            rcnt       <= LAST - 4'd1;
            keys_valid <= 1'b0;
            busy       <= 1'b1;
            state      <= EXPAND;
          end
        end
        EXPAND: begin
          if (rcnt == 4'd0) begin
            // Working key is dead after the final write, so it is left
            // alone and the generator inputs keep their last driven values.
            done       <= 1'b1;
            busy       <= 1'b0;
            keys_valid <= 1'b1;
            state      <= READY;
          end else begin
            work <= bus.gk_out_key;
            rcnt <= rcnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Registered read port; out-of-range indices return zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_key <= '0;
      rd_vld <= 1'b0;
    end else begin
      rd_vld <= 1'b0;
      if (bus.rd_en && keys_valid) begin
        rd_vld <= 1'b1;
        rd_key <= (bus.rd_idx > LAST) ? '0 : key_file[bus.rd_idx];
      end
    end
  end

  assign bus.gk_round   = rcnt;
  assign bus.gk_inp_key = work;
  assign bus.busy       = busy;
  assign bus.keys_valid = keys_valid;
  assign bus.done       = done;
  assign bus.rd_key     = rd_key;
  assign bus.rd_vld     = rd_vld;

endmodule

// File: tb/tb_inv_key_sched_ctrl.sv
// Directed bench for inv_key_sched_ctrl. Models the backward AES-128 key
// generator and checks sequencing, storage, read port and reset behaviour.
// Exercises key_err too when KSC_CHECK_EN is defined.
module tb_inv_key_sched_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [127:0] ek [0:10];

  localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] FIPS_K9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] FIPS_K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_B    = 128'h00112233445566778899aabbccddeeff;

  inv_key_sched_ctrl_if #(.KW(128)) bus ();

  inv_key_sched_ctrl #(.NR(10), .KW(128)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] v);
    logic [7:0] r = 8'h01;
    logic [7:0] p = v;
    logic [7:0] e = 8'd254;
    logic [7:0] b;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gmul(r, p);
      p = gmul(p, p);
    end
    b = r;
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input int n);
    logic [7:0] c = 8'h01;
    for (int i = 1; i < n; i++) c = {c[6:0], 1'b0} ^ (c[7] ? 8'h1b : 8'h00);
    return c;
  endfunction

  // Backward generator: round key (rnd+1) -> round key rnd
  function automatic logic [127:0] gen(input logic [127:0] k, input logic [3:0] rnd);
    logic [31:0] w0 = k[127:96];
    logic [31:0] w1 = k[95:64];
    logic [31:0] w2 = k[63:32];
    logic [31:0] w3 = k[31:0];
    logic [31:0] n3 = w3 ^ w2;
    logic [31:0] n2 = w2 ^ w1;
    logic [31:0] n1 = w1 ^ w0;
    logic [31:0] rw = {n3[23:0], n3[31:24]};
    logic [31:0] t;
    t = {sbox(rw[31:24]), sbox(rw[23:16]), sbox(rw[15:8]), sbox(rw[7:0])};
    t = t ^ {rcon(int'(rnd) + 1), 24'h0};
    return {w0 ^ t, n1, n2, n3};
  endfunction

  assign bus.gk_out_key = gen(bus.gk_inp_key, bus.gk_round);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic build_chain(input logic [127:0] k);
    ek[10] = k;
    for (int r = 9; r >= 0; r--) ek[r] = gen(ek[r+1], 4'(r));
  endtask

  // Start an expansion and follow it cycle by cycle to completion
  task automatic run_expand(input logic [127:0] k, input int poke, input bit sim_rd,
                            input logic [127:0] old_k10, input bit flip);
    build_chain(k);
    bus.last_key = k;
`ifdef KSC_CHECK_EN
    bus.exp_key0 = ek[0] ^ {127'd0, flip};
`endif
    bus.rd_en  = sim_rd;
    bus.rd_idx = 4'd10;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    bus.rd_en  = 1'b1;
    bus.rd_idx = 4'd0;
    if (sim_rd) check("start_read_key", bus.rd_key, old_k10);
    for (int s = 0; s < 10; s++) begin
      check("gk_round", {124'd0, bus.gk_round}, 128'(9 - s));
      check("gk_inp_key", bus.gk_inp_key, ek[10-s]);
      check("busy", {127'd0, bus.busy}, 128'd1);
      check("keys_valid_exp", {127'd0, bus.keys_valid}, 128'd0);
      check("done_exp", {127'd0, bus.done}, 128'd0);
      check("rd_vld_exp", {127'd0, bus.rd_vld}, (s == 0 && sim_rd) ? 128'd1 : 128'd0);
`ifdef KSC_CHECK_EN
      if (s == 0) check("key_err_clr", {127'd0, bus.key_err}, 128'd0);
`endif
      if (s == poke) begin
        bus.start    = 1'b1;
        bus.last_key = ~k;
      end
      tick();
      bus.start = 1'b0;
    end
    check("done_pulse", {127'd0, bus.done}, 128'd1);
    check("keys_valid", {127'd0, bus.keys_valid}, 128'd1);
    check("busy_end", {127'd0, bus.busy}, 128'd0);
    check("rd_vld_blocked", {127'd0, bus.rd_vld}, 128'd0);
`ifdef KSC_CHECK_EN
    check("key_err", {127'd0, bus.key_err}, {127'd0, flip});
`endif
    bus.rd_en = 1'b0;
    tick();
    check("done_once", {127'd0, bus.done}, 128'd0);
    $display("expansion of %h complete", k);
  endtask

  // Back-to-back reads of every stored key, then an out-of-range index
  task automatic read_all();
    bus.rd_en = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      bus.rd_idx = 4'(i);
      tick();
      check("rd_vld", {127'd0, bus.rd_vld}, 128'd1);
      check("rd_key", bus.rd_key, ek[i]);
      $display("read idx=%0d key=%h", i, bus.rd_key);
    end
    bus.rd_idx = 4'd12;
    tick();
    check("rd_vld_oor", {127'd0, bus.rd_vld}, 128'd1);
    check("rd_key_oor", bus.rd_key, 128'd0);
    $display("read idx=12 key=%h", bus.rd_key);
    bus.rd_en = 1'b0;
    tick();
    check("rd_vld_idle", {127'd0, bus.rd_vld}, 128'd0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"},  {127'd0, bus.busy}, 128'd0);
    check({tag, "_kv"},    {127'd0, bus.keys_valid}, 128'd0);
    check({tag, "_done"},  {127'd0, bus.done}, 128'd0);
    check({tag, "_rdvld"}, {127'd0, bus.rd_vld}, 128'd0);
    check({tag, "_rdkey"}, bus.rd_key, 128'd0);
    check({tag, "_round"}, {124'd0, bus.gk_round}, 128'd0);
    check({tag, "_inp"},   bus.gk_inp_key, 128'd0);
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.last_key = '0;
    bus.rd_en    = 1'b0;
    bus.rd_idx   = '0;
`ifdef KSC_CHECK_EN
    bus.exp_key0 = '0;
`endif
    #1;
    check_zero_outputs("reset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Read before any keys exist is ignored
    bus.rd_en  = 1'b1;
    bus.rd_idx = 4'd10;
    tick();
    check("rd_before_done", {127'd0, bus.rd_vld}, 128'd0);
    bus.rd_en = 1'b0;

    // FIPS-197 key, with a start poked mid-expansion
    run_expand(FIPS_K10, 3, 1'b0, '0, 1'b0);
    check("fips_k9_model", ek[9], FIPS_K9);
    read_all();
    bus.rd_en  = 1'b1;
    bus.rd_idx = 4'd0;
    tick();
    check("fips_k0_read", bus.rd_key, FIPS_K0);
    bus.rd_idx = 4'd9;
    tick();
    check("fips_k9_read", bus.rd_key, FIPS_K9);
    bus.rd_idx = 4'd10;
    tick();
    check("fips_k10_read", bus.rd_key, FIPS_K10);
    bus.rd_en = 1'b0;
    tick();

    // Restart from READY with a read in the same cycle
    run_expand(KEY_B, -1, 1'b1, FIPS_K10, 1'b1);
    read_all();

    // Reset in the middle of an expansion
    bus.last_key = FIPS_K10;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    check("mid_round", {124'd0, bus.gk_round}, 128'd5);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("mid_reset");
    tick();
    rst_n = 1'b1;
    tick();
    check("post_reset_idle", {127'd0, bus.busy}, 128'd0);

    // Full expansion after reset
    run_expand(FIPS_K10, -1, 1'b0, '0, 1'b0);
    read_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/inv_key_sched_ctrl.md
Name: inv_key_sched_ctrl

Overview:
Sequencer for the AES-128 decrypter's backward key expansion. It loads the final (round-10) key and drives the external combinational backward key generator (GENERATE_KEY) once per cycle, with round = 9 down to 0. It stores all 11 round keys in a local key file. The decryption round datapath reads keys from that file by index.

Parameters:
NR, 10, number of AES rounds; key file depth is NR+1.
KW, 128, round key width in bits.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
start  in  1  one-cycle pulse; load last_key and begin expansion.
last_key  in  KW  round-NR key; sampled on an accepted start.
gk_round  out  4  round input to the generator.
gk_inp_key  out  KW  inp_key input to the generator (current working key).
gk_out_key  in  KW  out_key returned combinationally by the generator.
busy  out  1  high while expansion is in progress.
keys_valid  out  1  high when all NR+1 keys are stored and readable.
done  out  1  one-cycle pulse on the final expansion write.
rd_en  in  1  key read request.
rd_idx  in  4  round index to read, 0..NR.
rd_key  out  KW  registered read data.
rd_vld  out  1  one-cycle pulse, qualifies rd_key.

Behaviour:
- Reset values: busy=0, keys_valid=0, done=0, rd_vld=0, rd_key=0, gk_round=0, gk_inp_key=0, state=IDLE. Key file contents are don't-care after reset.
- States:
  - IDLE: waiting for start.
  - EXPAND: expansion running.
  - READY: keys stored and readable.
- IDLE/READY, start=1:
  - working register <= last_key; key_file[NR] <= last_key.
  - rcnt <= NR-1; keys_valid <= 0; busy <= 1; go to EXPAND.
- EXPAND, each cycle:
  - gk_inp_key = working register; gk_round = rcnt.
  - key_file[rcnt] <= gk_out_key; working register <= gk_out_key.
  - If rcnt==0: done <= 1, busy <= 0, keys_valid <= 1, go to READY. Otherwise rcnt <= rcnt-1.
- Latency: start accepted in cycle T. Writes occur in cycles T+1..T+NR. done and keys_valid are seen high at T+NR+1. That is 10 expansion cycles for NR=10.
- start while in EXPAND: ignored; the sequence completes unchanged.
- start in READY: restarts expansion. keys_valid drops the next cycle. Old keys are not readable until done.
- Outside EXPAND: gk_round and gk_inp_key hold their last values; no writes occur.
- Read port:
  - Accepted when rd_en=1 and keys_valid=1 in the same cycle.
  - rd_key = key_file[rd_idx] and rd_vld=1 on the next cycle.
  - rd_idx>NR: rd_key=0, rd_vld=1.
  - rd_en while keys_valid=0: ignored, rd_vld stays 0.
  - Back-to-back reads are allowed, one per cycle.
- Simultaneous start and rd_en in READY: the read is serviced from the old contents. Expansion starts the same cycle.
- rst_n asserted mid-EXPAND: immediate return to the reset values. A new start is required.

Optional Feature:
Macro KSC_CHECK_EN.
- Defined: adds input exp_key0 (KW) and output key_err (1).
  - exp_key0 is sampled with last_key on an accepted start.
  - On the rcnt==0 write, key_err <= (gk_out_key != sampled exp_key0).
  - key_err holds until the next accepted start or reset; both clear it to 0.
- Undefined: neither port exists and no compare logic is built.

Test Plan:
- Reset, then start with a FIPS-197 round-10 key (packed in the generator's word order) -> busy high for 10 cycles; gk_round sequence is 9,8,...,0; done pulses once at T+11; keys_valid=1.
- After expansion, read rd_idx 0..10 back-to-back -> rd_vld pulses on 11 consecutive cycles; each rd_key matches the golden generator model; idx 10 returns last_key; idx 0 returns the cipher key.
- rd_idx=12 in READY -> rd_key=0, rd_vld=1; rd_en before the first done -> rd_vld stays 0.
- Second start at cycle T+4 during EXPAND -> ignored; done still at T+11. Then start in READY with a new key -> keys_valid=0 at the next cycle, new keys valid 11 cycles after that start.
- rst_n pulsed low at rcnt=5 -> all outputs 0 immediately; a later start gives a full, correct expansion.
- KSC_CHECK_EN: correct exp_key0 -> key_err=0; exp_key0 with one bit flipped -> key_err=1 after done, cleared by the next start.
